// File: rtl/dds_spi_ctrl_if.sv
// Register-bank side of the DDS serial engine: request pulse, frame word, controls and results.
interface dds_spi_ctrl_if;
    logic        Start;
    logic        Busy;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        WR;
    logic        Send;

    modport master (output Start, DataOut, WR, Send, input Busy, DataIn);
    modport slave  (input Start, DataOut, WR, Send, output Busy, DataIn);
endinterface

// File: rtl/dds_spi_ctrl.sv
// 32-bit MSB-first frame engine for the DDS 3-wire serial port, with optional IO_UPDATE pulse.
// Handshake: a one-cycle Start is accepted only in IDLE; Busy stays high until the frame and any update pulse end.
module dds_spi_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int UPD_W   = 8
) (
    input  logic          APB_0_axiclk,
    input  logic          APB_0_aresetn,
    dds_spi_ctrl_if.slave bus,
    output logic          dds_cs_n,
    output logic          dds_sclk,
    output logic          dds_sdio_o,
    output logic          dds_sdio_oe,
    input  logic          dds_sdo,
    output logic          dds_io_update,
    output logic [2:0]    dbg_state
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] SHIFT  = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] UPD_LAST = 8'(UPD_W - 1);

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [7:0]  upd_cnt;
    logic [31:0] tx_sh;
    logic [23:0] rx_sh;
    logic        sh_wr;
    logic        sh_send;
    logic        busy_q;
    logic [31:0] data_in_q;
    logic        div_last;

    assign div_last    = (div_cnt == DIV_LAST);
    assign bus.Busy    = busy_q;
    assign bus.DataIn  = data_in_q;
    assign dbg_state   = state;

    always_ff @(posedge APB_0_axiclk) begin
        if (!APB_0_aresetn) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            upd_cnt       <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            sh_wr         <= 1'b0;
            sh_send       <= 1'b0;
            busy_q        <= 1'b0;
            data_in_q     <= '0;
            dds_cs_n      <= 1'b1;
            dds_sclk      <= 1'b0;
            dds_sdio_o    <= 1'b0;
            dds_sdio_oe   <= 1'b0;
            dds_io_update <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        tx_sh       <= bus.DataOut;
                        sh_wr       <= bus.WR;
                        sh_send     <= bus.Send;
                        busy_q      <= 1'b1;
                        dds_cs_n    <= 1'b0;
                        dds_sdio_oe <= 1'b1;
                        dds_sdio_o  <= bus.DataOut[31];
                        div_cnt     <= '0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!dds_sclk) begin
                            dds_sclk <= 1'b1;
                            // Read data occupies bits 8..31, sampled as SCLK rises.
                            if (!sh_wr && bit_cnt >= 5'd8)
                                rx_sh <= {rx_sh[22:0], dds_sdo};
                        end else begin
                            dds_sclk <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt    <= bit_cnt + 5'd1;
                                tx_sh      <= {tx_sh[30:0], 1'b0};
                                dds_sdio_o <= tx_sh[30];
                                if (!sh_wr && bit_cnt == 5'd7)
                                    dds_sdio_oe <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt     <= '0;
                        dds_cs_n    <= 1'b1;
                        dds_sdio_oe <= 1'b0;
                        dds_sdio_o  <= 1'b0;
                        if (!sh_wr)
                            data_in_q <= {8'h00, rx_sh};
                        if (sh_wr && sh_send) begin
                            dds_io_update <= 1'b1;
                            upd_cnt       <= '0;
                            state         <= UPDATE;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                UPDATE: begin
                    if (upd_cnt == UPD_LAST) begin
                        dds_io_update <= 1'b0;
                        busy_q        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        upd_cnt <= upd_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
